// File: rtl/onchip_ram_burst_slave_pkg.sv
// Shared definitions for the burst-capable on-chip RAM slave.
package onchip_ram_burst_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   localparam int MAX_READ_LATENCY = 2;

   // Number of address bits needed to index `value` words (minimum 1).
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/onchip_ram_burst_slave_array.sv
// Single-port synchronous RAM with byte enables and clock enable.
// One access per enabled cycle, so a read always returns the data stored
// before any later write to the same word (read-old-data).
module onchip_ram_burst_slave_array #(
   parameter int    DATA_WIDTH = 32,
   parameter int    DEPTH      = 4096,
   parameter int    ADDR_WIDTH = 12,
   parameter string INIT_FILE  = ""
) (
   input  logic                      i_clk,
   input  logic                      i_clken,
   input  logic                      i_we,
   input  logic [DATA_WIDTH/8-1:0]   i_byteen,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   input  logic                      i_re,
   input  logic                      i_rblank,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   output logic [DATA_WIDTH-1:0]     o_rdata
);

   localparam int NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Byte-masked write port.
   always_ff @(posedge i_clk) begin
      if (i_clken && i_we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (i_byteen[b]) begin
               r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Registered read; blanked reads (out-of-range bursts) return zero.
   always_ff @(posedge i_clk) begin
      if (i_clken && i_re) begin
         r_rdata <= i_rblank ? '0 : r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/onchip_ram_burst_slave.sv
// Avalon-MM burst slave in front of one on-chip RAM array.
// Linear read/write bursts with wrap modulo DEPTH, pipelined reads with
// READ_LATENCY of 1 or 2 enabled cycles, and a global clock enable.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | accepting a new command; beat 0 is served in the accept cycle
//   ST_RD    | issuing remaining read addresses, one per enabled cycle
//   ST_WR    | accepting remaining write beats; write=0 cycles are idle
module onchip_ram_burst_slave
   import onchip_ram_burst_slave_pkg::*;
#(
   parameter int    DATA_WIDTH   = 32,
   parameter int    DEPTH        = 4096,
   parameter int    ADDR_WIDTH   = 12,
   parameter int    BURST_WIDTH  = 4,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = ""
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_chipselect,
   input  logic                      i_read,
   input  logic                      i_write,
   input  logic [ADDR_WIDTH-1:0]     i_address,
   input  logic [BURST_WIDTH-1:0]    i_burstcount,
   input  logic [DATA_WIDTH/8-1:0]   i_byteenable,
   input  logic [DATA_WIDTH-1:0]     i_writedata,
   input  logic                      i_clken,
   output logic                      o_waitrequest,
   output logic [DATA_WIDTH-1:0]     o_readdata,
   output logic                      o_readdatavalid
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   generate
      if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_latency
         $error("onchip_ram_burst_slave: READ_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
         $error("onchip_ram_burst_slave: DATA_WIDTH must be a multiple of 8");
      end
      if (clog2(DEPTH) > ADDR_WIDTH) begin : g_bad_addr
         $error("onchip_ram_burst_slave: ADDR_WIDTH too small for DEPTH");
      end
   endgenerate

   // Successor address with wrap at DEPTH, valid for non-power-of-2 depths.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   state_t                   r_state, w_state_nxt;
   logic [BURST_WIDTH-1:0]   r_beats_left, w_beats_nxt;
   logic [ADDR_WIDTH-1:0]    r_addr, w_addr_nxt;
   logic                     r_oor, w_oor_nxt;

   logic [BURST_WIDTH-1:0]   w_burst_len;
   logic                     w_start_oor;
   logic                     w_cmd;

   logic                     w_ram_rd, w_ram_wr, w_ram_blank;
   logic [ADDR_WIDTH-1:0]    w_ram_addr;
   logic [DATA_WIDTH-1:0]    w_ram_q, w_pipe_data, r_rdata_hold;
   logic [READ_LATENCY-1:0]  r_vld;

   assign w_burst_len = (i_burstcount == '0) ? BURST_WIDTH'(1) : i_burstcount;
   assign w_start_oor = ({1'b0, i_address} >= DEPTH_W);
   assign w_cmd       = i_chipselect && (i_write || i_read);

   // State register plus burst beat/address tracking.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= ST_IDLE;
         r_beats_left <= '0;
         r_addr       <= '0;
         r_oor        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_beats_left <= w_beats_nxt;
         r_addr       <= w_addr_nxt;
         r_oor        <= w_oor_nxt;
      end
   end

   // Next-state: a multi-beat command opens a burst; each served beat counts down.
   always_comb begin
      w_state_nxt = r_state;
      w_beats_nxt = r_beats_left;
      w_addr_nxt  = r_addr;
      w_oor_nxt   = r_oor;
      if (i_clken) begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd && (w_burst_len != BURST_WIDTH'(1))) begin
                  w_state_nxt = i_write ? ST_WR : ST_RD;
                  w_beats_nxt = w_burst_len - BURST_WIDTH'(1);
                  w_addr_nxt  = next_addr(i_address);
                  w_oor_nxt   = w_start_oor;
               end
            end
            ST_RD: begin
               w_beats_nxt = r_beats_left - BURST_WIDTH'(1);
               w_addr_nxt  = next_addr(r_addr);
               if (r_beats_left == BURST_WIDTH'(1)) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_WR: begin
               if (i_write) begin
                  w_beats_nxt = r_beats_left - BURST_WIDTH'(1);
                  w_addr_nxt  = next_addr(r_addr);
                  if (r_beats_left == BURST_WIDTH'(1)) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs: array access for the current beat and waitrequest.
   always_comb begin
      w_ram_rd      = 1'b0;
      w_ram_wr      = 1'b0;
      w_ram_addr    = i_address;
      w_ram_blank   = w_start_oor;
      o_waitrequest = 1'b1;
      if (i_clken) begin
         case (r_state)
            ST_IDLE: begin
               o_waitrequest = 1'b0;
               if (i_chipselect && i_write) begin
                  w_ram_wr = !w_start_oor;
               end else if (i_chipselect && i_read) begin
                  w_ram_rd = 1'b1;
               end
            end
            ST_RD: begin
               w_ram_rd    = 1'b1;
               w_ram_addr  = r_addr;
               w_ram_blank = r_oor;
            end
            ST_WR: begin
               o_waitrequest = 1'b0;
               w_ram_addr    = r_addr;
               w_ram_blank   = r_oor;
               w_ram_wr      = i_write && !r_oor;
            end
            default: o_waitrequest = 1'b1;
         endcase
      end
   end

   onchip_ram_burst_slave_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .i_clk    (i_clk),
      .i_clken  (i_clken),
      .i_we     (w_ram_wr),
      .i_byteen (i_byteenable),
      .i_wdata  (i_writedata),
      .i_re     (w_ram_rd),
      .i_rblank (w_ram_blank),
      .i_addr   (w_ram_addr),
      .o_rdata  (w_ram_q)
   );

   // Valid shift pipeline; advances only on enabled cycles.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vld <= '0;
      end else if (i_clken) begin
         r_vld[0] <= w_ram_rd;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign w_pipe_data = w_ram_q;
      end else begin : g_lat2
         logic [DATA_WIDTH-1:0] r_rdata_s2;
         // Extra data stage for the two-cycle read path.
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               r_rdata_s2 <= '0;
            end else if (i_clken && r_vld[0]) begin
               r_rdata_s2 <= w_ram_q;
            end
         end
         assign w_pipe_data = r_rdata_s2;
      end
   endgenerate

   assign o_readdatavalid = i_clken && r_vld[READ_LATENCY-1];

   // Keeps readdata stable between valid beats, including across stalls.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rdata_hold <= '0;
      end else if (o_readdatavalid) begin
         r_rdata_hold <= w_pipe_data;
      end
   end

   assign o_readdata = o_readdatavalid ? w_pipe_data : r_rdata_hold;

endmodule
